// File: rtl/y86_mem_pkg.sv
// Shared definitions for the Y86-64 data-memory path: default geometry,
// read-return owner encoding and the icodes of instructions that touch data memory.
package y86_mem_pkg;

    localparam int DMEM_ADDR_W  = 10;
    localparam int DMEM_DATA_W  = 64;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    function automatic logic is_mem_icode(input logic [3:0] icode);
        return (icode == I_RMMOVQ) || (icode == I_MRMOVQ) || (icode == I_CALL) ||
               (icode == I_RET)    || (icode == I_PUSHQ)  || (icode == I_POPQ);
    endfunction

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating count of consecutive cycles the loader/debug port has been refused.
// Clears on any cycle it is not refused; at_max_o flags that it now has priority.
module dmem_starve_ctr
    import y86_mem_pkg::*;
#(
    parameter int unsigned MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inc_i,
    output logic [STARVE_CNT_W-1:0] count_o,
    output logic                    at_max_o
);

    localparam logic [STARVE_CNT_W-1:0] MAX_CNT = STARVE_CNT_W'(MAX);

    logic [STARVE_CNT_W-1:0] count_q;
    logic [STARVE_CNT_W-1:0] count_d;

    always_comb begin
        count_d = '0;
        if (inc_i) begin
            count_d = (count_q == MAX_CNT) ? count_q : count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign at_max_o = (count_q == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the pipeline memory stage (M, fixed
// priority) and the loader/debug port (D, guarded against starvation).
module dmem_arbiter
    import y86_mem_pkg::*;
#(
    parameter int          ADDR_W     = DMEM_ADDR_W,
    parameter int          DATA_W     = DMEM_DATA_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m_req,
    input  logic              m_we,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    output logic              m_gnt,
    output logic              m_stall,
    output logic              m_rvalid,
    output logic [DATA_W-1:0] m_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    owner_e                  rd_owner_q;
    owner_e                  rd_owner_d;
    logic                    starve_at_max;
    logic [STARVE_CNT_W-1:0] starve_cnt;

    dmem_starve_ctr #(
        .MAX      (STARVE_MAX)
    ) u_starve_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_i    (d_req & ~d_gnt),
        .count_o  (starve_cnt),
        .at_max_o (starve_at_max)
    );

    // Grants are qualified with rst_n so the array sees no access while reset is held.
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        d_gnt      = rst_n & d_req & (~m_req | starve_at_max);
        m_gnt      = rst_n & m_req & ~d_gnt;
        m_stall    = m_req & ~m_gnt;

        mem_en     = m_gnt | d_gnt;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rd_owner_d = OWN_NONE;

        if (m_gnt) begin
            mem_we     = m_we;
            mem_addr   = m_addr;
            mem_wdata  = m_wdata;
            rd_owner_d = m_we ? OWN_NONE : OWN_M;
        end else if (d_gnt) begin
            mem_we     = d_we;
            mem_addr   = d_addr;
            mem_wdata  = d_wdata;
            rd_owner_d = d_we ? OWN_NONE : OWN_D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_owner_q <= OWN_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    // The array registers its read data, so the owner captured at grant steers it back.
    assign m_rvalid = (rd_owner_q == OWN_M);
    assign d_rvalid = (rd_owner_q == OWN_D);
    assign m_rdata  = m_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule
